// File: rtl/avalon_pio_pkg.sv
// Shared constants for the Avalon-MM PIO: register map, edge selection and IRQ source.
// Also holds a helper that sizes the settle counter from the synchroniser depth.
package avalon_pio_pkg;

   localparam logic [2:0] ADDR_DATA    = 3'd0;
   localparam logic [2:0] ADDR_DIR     = 3'd1;
   localparam logic [2:0] ADDR_IRQMASK = 3'd2;
   localparam logic [2:0] ADDR_EDGECAP = 3'd3;
   localparam logic [2:0] ADDR_OUTSET  = 3'd4;
   localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

   localparam int IRQ_LEVEL = 0;
   localparam int IRQ_EDGE  = 1;

   // The settle counter has to hold every value from 0 to stages+1.
   function automatic int settle_cnt_width(input int stages);
      return $clog2(stages + 2);
   endfunction

endpackage

// File: rtl/pio_edge_capture.sv
// Input synchroniser, previous-sample register, post-reset settle guard and
// per-bit edge-capture register with a write-1-to-clear port.
module pio_edge_capture
   import avalon_pio_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_TYPE   = EDGE_RISE
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] i_in_port,
   input  logic [DATA_WIDTH-1:0] i_clr,
   output logic [DATA_WIDTH-1:0] o_sync_in,
   output logic [DATA_WIDTH-1:0] o_edgecap
);

   localparam int              CNT_W      = settle_cnt_width(SYNC_STAGES);
   localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SYNC_STAGES + 1);

   logic [DATA_WIDTH-1:0] r_sync [SYNC_STAGES];
   logic [DATA_WIDTH-1:0] r_prev;
   logic [DATA_WIDTH-1:0] r_cap;
   logic [CNT_W-1:0]      r_settle;

   logic                  w_settled;
   logic [DATA_WIDTH-1:0] w_edge;
   logic [DATA_WIDTH-1:0] w_set;

   // NOTE: the synchroniser is a register array, not a RAM, so every stage is
   // reset; otherwise a stale 1 could walk out of it as a false edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
         r_prev   <= '0;
         r_settle <= '0;
      end else begin
         r_sync[0] <= i_in_port;
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
         r_prev <= r_sync[SYNC_STAGES-1];
         if (!w_settled) r_settle <= r_settle + 1'b1;
      end
   end

   assign o_sync_in = r_sync[SYNC_STAGES-1];
   assign w_settled = (r_settle == SETTLE_MAX);

   // NOTE: w_edge gets a value on every path before any branch, so no latch is inferred.
   always_comb begin
      w_edge = o_sync_in & ~r_prev;
      if (EDGE_TYPE == EDGE_FALL)
         w_edge = ~o_sync_in & r_prev;
      else if (EDGE_TYPE == EDGE_ANY)
         w_edge = o_sync_in ^ r_prev;
   end

   // Pins held high through reset look like rising edges until the chain fills.
   assign w_set = w_settled ? w_edge : '0;

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_cap <= '0;
      else       r_cap <= (r_cap & ~i_clr) | w_set;
   end

   assign o_edgecap = r_cap;

endmodule

// File: rtl/avalon_pio_gen2.sv
// Parametrised Avalon-MM PIO: output data with atomic set/clear, per-bit direction,
// synchronised inputs, edge capture and a masked interrupt. Zero-wait-state slave.
module avalon_pio_gen2
   import avalon_pio_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 8,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
   parameter logic [DATA_WIDTH-1:0] RESET_DIR   = '0,
   parameter int                    EDGE_TYPE   = EDGE_RISE,
   parameter int                    IRQ_TYPE    = IRQ_LEVEL,
   parameter int                    SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [2:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   input  logic [DATA_WIDTH-1:0] in_port,
   output logic [DATA_WIDTH-1:0] out_port,
   output logic [DATA_WIDTH-1:0] oe,
   output logic                  irq
);

   logic [DATA_WIDTH-1:0] r_data;
   logic [DATA_WIDTH-1:0] r_dir;
   logic [DATA_WIDTH-1:0] r_mask;

   logic                  w_wr;
   logic [DATA_WIDTH-1:0] w_wd;
   logic [DATA_WIDTH-1:0] w_clr;
   logic [DATA_WIDTH-1:0] w_sync_in;
   logic [DATA_WIDTH-1:0] w_edgecap;

   assign w_wr  = chipselect & ~write_n;
   assign w_wd  = writedata[DATA_WIDTH-1:0];
   assign w_clr = (w_wr && address == ADDR_EDGECAP) ? w_wd : '0;

   if (DATA_WIDTH < 32) begin : g_wd_upper
      logic w_unused_wd;
      assign w_unused_wd = |writedata[31:DATA_WIDTH];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_data <= RESET_VALUE;
         r_dir  <= RESET_DIR;
         r_mask <= '0;
      end else if (w_wr) begin
         case (address)
            ADDR_DATA:    r_data <= w_wd;
            ADDR_DIR:     r_dir  <= w_wd;
            ADDR_IRQMASK: r_mask <= w_wd;
            ADDR_OUTSET:  r_data <= r_data | w_wd;
            ADDR_OUTCLR:  r_data <= r_data & ~w_wd;
            default:      ;
         endcase
      end
   end

   pio_edge_capture #(
      .DATA_WIDTH  (DATA_WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_TYPE   (EDGE_TYPE)
   ) u_edge (
      .clk       (clk),
      .reset     (reset),
      .i_in_port (in_port),
      .i_clr     (w_clr),
      .o_sync_in (w_sync_in),
      .o_edgecap (w_edgecap)
   );

   // Zero-latency read: a pure mux of registered state.
   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA:    readdata[DATA_WIDTH-1:0] = (r_dir & r_data) | (~r_dir & w_sync_in);
         ADDR_DIR:     readdata[DATA_WIDTH-1:0] = r_dir;
         ADDR_IRQMASK: readdata[DATA_WIDTH-1:0] = r_mask;
         ADDR_EDGECAP: readdata[DATA_WIDTH-1:0] = w_edgecap;
         default:      readdata = '0;
      endcase
   end

   assign irq      = (IRQ_TYPE == IRQ_EDGE) ? |(w_edgecap & r_mask) : |(w_sync_in & r_mask);
   assign out_port = r_data;
   assign oe       = r_dir;

endmodule

// File: doc/avalon_pio_gen2.md
Name: avalon_pio_gen2

Overview:
- Parametrised successor to the single-bit Avalon-MM output PIO used for SD_CLK and similar strobes.
- Generalises it to DATA_WIDTH bits with per-bit direction.
- Adds a synchronised input path, edge capture, interrupt mask/IRQ and atomic bit set/clear registers.
- Sits on the system Avalon-MM interconnect as a fixed-latency slave with no wait states; drives and samples board pins (SD_CMD, SD_DAT, LEDs, keys).

Parameters:
- DATA_WIDTH, 8: port width, 1..32.
- RESET_VALUE, 0: reset value of the output data register (DATA_WIDTH bits).
- RESET_DIR, 0: reset value of the direction register; 1 = output.
- EDGE_TYPE, 0: edge that sets capture bits; 0 = rising, 1 = falling, 2 = any.
- IRQ_TYPE, 0: 0 = level IRQ from synchronised inputs, 1 = IRQ from edge-capture bits.
- SYNC_STAGES, 2: input synchroniser depth, 2..4.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset.
- address  in  3  Avalon word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits above DATA_WIDTH are ignored.
- readdata  out  32  read data; bits above DATA_WIDTH read 0.
- in_port  in  DATA_WIDTH  asynchronous pin inputs.
- out_port  out  DATA_WIDTH  output data register.
- oe  out  DATA_WIDTH  per-bit output enable, equal to the direction register.
- irq  out  1  interrupt request, active-high.

Interface decision: one clock, clk. Reset port reset is asynchronous and active-high. All registers clear or preset on the rising edge of reset, independent of clk.

Behaviour:
- A write is chipselect & ~write_n, sampled on the rising edge of clk.
- Register map:
  - addr 0 DATA: write loads data_out. Read returns (dir & data_out) | (~dir & sync_in).
  - addr 1 DIR: R/W, loads dir.
  - addr 2 IRQMASK: R/W, loads mask.
  - addr 3 EDGECAP: read returns capture bits. Write is write-1-to-clear per bit.
  - addr 4 OUTSET: write gives data_out |= wd. Reads 0.
  - addr 5 OUTCLR: write gives data_out &= ~wd. Reads 0.
  - addr 6-7: reserved; writes ignored, reads 0.
- Read path: readdata is a combinational mux of registered state (read latency 0). readdata is valid in the same cycle as chipselect, and 0 when address is unmapped.
- Reset values:
  - data_out = RESET_VALUE, dir = RESET_DIR, mask = 0, edgecap = 0.
  - Synchroniser and previous-sample registers = 0.
  - Settle counter = 0, irq = 0.
- Synchroniser: SYNC_STAGES flops per bit. sync_in lags in_port by SYNC_STAGES cycles. A previous-sample register holds sync_in delayed by one cycle.
- Edge detect per bit:
  - rise = sync_in & ~prev; fall = ~sync_in & prev; any = rise | fall, selected by EDGE_TYPE.
  - Detection applies to all bits, whatever their dir.
- Settle guard: a counter runs 0..SYNC_STAGES+1 after reset, then saturates. Edge detect is masked until the counter saturates. This prevents false edges from pins held high through reset.
- Edge capture: a capture bit sets on a detected edge and holds until cleared. If a set and a W1C clear hit the same bit in the same cycle, set wins.
- IRQ:
  - IRQ_TYPE 0: irq = |(sync_in & mask).
  - IRQ_TYPE 1: irq = |(edgecap & mask).
  - irq is combinational from registers and deasserts the cycle after the causing bits clear.
- Width: writes use writedata[DATA_WIDTH-1:0]. For DATA_WIDTH = 32 every bit is significant.
- Reset mid-transaction: the write is lost, all state returns to reset values and the settle guard restarts.

Decomposition:
- Package avalon_pio_pkg holds:
  - address constants: ADDR_DATA=0, ADDR_DIR=1, ADDR_IRQMASK=2, ADDR_EDGECAP=3, ADDR_OUTSET=4, ADDR_OUTCLR=5;
  - EDGE_RISE/EDGE_FALL/EDGE_ANY;
  - IRQ_LEVEL/IRQ_EDGE.
- Sub-module pio_edge_capture holds the synchroniser, previous-sample register, settle counter and capture register with the W1C port, parametrised by DATA_WIDTH, SYNC_STAGES and EDGE_TYPE.
- The top holds the register file, read mux and irq.

Test Plan:
- Reset/readback: DW=8, RESET_VALUE=8'hA5, RESET_DIR=8'hFF → out_port=A5, oe=FF, read addr0=A5, addr2=0, addr3=0, irq=0. Read addr6 → 0.
- Set/clear: write DATA=0x0F, OUTSET=0xC0, OUTCLR=0x03 → out_port=0x0F, then 0xCF, then 0xCC. Writedata 0xFFFFFF00 to DATA → out_port=0x00.
- Mixed direction: DIR=0xF0, data_out=0xFF, in_port=0x05 → addr0 read = 0xF5 exactly SYNC_STAGES cycles after in_port changes, not earlier.
- Edge capture + IRQ (IRQ_TYPE=1, rising): mask=0x01, pulse in_port[0] low→high → edgecap=0x01 and irq=1 at cycle SYNC_STAGES+1. W1C 0x01 → edgecap=0, irq=0 next cycle. W1C on the same cycle as a new edge → bit stays 1.
- Settle guard: hold in_port=0xFF through reset release → edgecap stays 0 forever. Then falling-edge config, drop in_port[3] → edgecap=0x08.
- Reset mid-operation: assert reset during a DATA write with edgecap=0x3 → all registers return to reset values immediately (async) and irq=0.
